// File: rtl/z80_dma_ctrl.sv
// z80_dma_ctrl: CPU-programmed memory-to-memory block DMA that borrows the tv80s bus via busrq_n/busak_n.
// Optional macro DMA_FAIR_EN splits a transfer into BURST_LEN-byte bus tenures so the CPU can run between them.

module z80_dma_ctrl #(
   parameter logic [7:0] IO_BASE   = 8'h40,
   parameter int         BURST_LEN = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  cpu_a,
   input  logic [7:0]  cpu_do,
   input  logic        cpu_iorq_n,
   input  logic        cpu_rd_n,
   input  logic        cpu_wr_n,
   output logic [7:0]  io_rdata,
   output logic        io_hit,
   output logic        busrq_n,
   input  logic        busak_n,
   output logic [15:0] dma_a,
   output logic [7:0]  dma_do,
   input  logic [7:0]  dma_di,
   output logic        dma_mreq_n,
   output logic        dma_rd_n,
   output logic        dma_wr_n,
   output logic        dma_done
);

   typedef enum logic [2:0] {
      IDLE, REQ, RD1, RD2, WR1, WR2, STEP, REL
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] src_q, src_d;
   logic [15:0] dst_q, dst_d;
   logic [15:0] len_q, len_d;
   logic        dir_q, dir_d;
   logic        done_q, done_d;
   logic [7:0]  dmaDo_q, dmaDo_d;
   logic        wrPrev_q;

   logic        decode;
   logic        wrStrobe;
   logic        wrAccept;
   logic        busy;
   logic        burstEnd;
   logic [2:0]  offset;
   logic [7:0]  rdMux;

   assign decode   = (cpu_a[7:3] == IO_BASE[7:3]);
   assign offset   = cpu_a[2:0];
   assign wrStrobe = ~cpu_iorq_n & ~cpu_wr_n & decode;
   assign wrAccept = wrStrobe & ~wrPrev_q;
   assign busy     = (state_q != IDLE);

`ifdef DMA_FAIR_EN
   localparam logic [7:0] BurstLen = 8'(BURST_LEN);

   logic [7:0] tenure_q, tenure_d;

   // Bytes moved in the current grant; REQ is visited before every grant so it clears there.
   always_comb begin
      tenure_d = tenure_q;
      if (state_q == REQ) begin
         tenure_d = 8'd0;
      end else if (state_q == STEP) begin
         tenure_d = tenure_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tenure_q <= 8'd0;
      end else begin
         tenure_q <= tenure_d;
      end
   end

   assign burstEnd = ((tenure_q + 8'd1) == BurstLen);
`else
   logic unusedBurst;
   assign unusedBurst = (BURST_LEN == 0);
   assign burstEnd    = 1'b0;
`endif

   // CPU register writes first, then the sequencer, so FSM updates (done, counters) take priority.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      dir_d   = dir_q;
      done_d  = done_q;
      dmaDo_d = dmaDo_q;

      if (wrAccept) begin
         unique case (offset)
            3'd0: if (!busy) src_d[7:0]  = cpu_do;
            3'd1: if (!busy) src_d[15:8] = cpu_do;
            3'd2: if (!busy) dst_d[7:0]  = cpu_do;
            3'd3: if (!busy) dst_d[15:8] = cpu_do;
            3'd4: if (!busy) len_d[7:0]  = cpu_do;
            3'd5: if (!busy) len_d[15:8] = cpu_do;
            3'd6: begin
               if (cpu_do[2]) done_d = 1'b0;
               if (cpu_do[0] && !busy) begin
                  dir_d   = cpu_do[1];
                  state_d = REQ;
               end
            end
            default: ;
         endcase
      end

      unique case (state_q)
         IDLE: ;
         REQ:  if (!busak_n) state_d = RD1;
         RD1:  state_d = RD2;
         RD2: begin
            dmaDo_d = dma_di;
            state_d = WR1;
         end
         WR1:  state_d = WR2;
         WR2:  state_d = STEP;
         STEP: begin
            src_d = dir_q ? (src_q - 16'd1) : (src_q + 16'd1);
            dst_d = dir_q ? (dst_q - 16'd1) : (dst_q + 16'd1);
            len_d = len_q - 16'd1;
            if ((len_q == 16'd1) || burstEnd) begin
               state_d = REL;
            end else begin
               state_d = RD1;
            end
         end
         REL: begin
            // A nonzero length here can only come from a burst split, so re-request instead of finishing.
            if (busak_n) begin
               if (len_q != 16'd0) begin
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         src_q    <= 16'd0;
         dst_q    <= 16'd0;
         len_q    <= 16'd0;
         dir_q    <= 1'b0;
         done_q   <= 1'b0;
         dmaDo_q  <= 8'd0;
         wrPrev_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         dir_q    <= dir_d;
         done_q   <= done_d;
         dmaDo_q  <= dmaDo_d;
         wrPrev_q <= wrStrobe;
      end
   end

   // Bus outputs decode straight from the state register so an async reset drops them at once.
   always_comb begin
      busrq_n    = 1'b1;
      dma_mreq_n = 1'b1;
      dma_rd_n   = 1'b1;
      dma_wr_n   = 1'b1;
      dma_a      = 16'h0000;
      unique case (state_q)
         REQ:  busrq_n = 1'b0;
         RD1, RD2: begin
            busrq_n    = 1'b0;
            dma_mreq_n = 1'b0;
            dma_rd_n   = 1'b0;
            dma_a      = src_q;
         end
         WR1, WR2: begin
            busrq_n    = 1'b0;
            dma_mreq_n = 1'b0;
            dma_wr_n   = 1'b0;
            dma_a      = dst_q;
         end
         STEP: busrq_n = 1'b0;
         default: ;
      endcase
   end

   assign dma_do   = dmaDo_q;
   assign dma_done = done_q;

   always_comb begin
      rdMux = 8'h00;
      unique case (offset)
         3'd0: rdMux = src_q[7:0];
         3'd1: rdMux = src_q[15:8];
         3'd2: rdMux = dst_q[7:0];
         3'd3: rdMux = dst_q[15:8];
         3'd4: rdMux = len_q[7:0];
         3'd5: rdMux = len_q[15:8];
         3'd6: rdMux = 8'h00;
         3'd7: rdMux = {6'b000000, done_q, busy};
         default: ;
      endcase
   end

   assign io_hit   = reset_n & ~cpu_iorq_n & ~cpu_rd_n & decode;
   assign io_rdata = io_hit ? rdMux : 8'h00;

endmodule

// File: doc/z80_dma_ctrl.md
Name: z80_dma_ctrl

Overview:
Block-transfer DMA controller sharing the flat 64 KiB memory between the tv80s core and a DMA engine. The CPU programs it through eight I/O ports. It requests the bus with busrq_n and waits for busak_n. It then copies LEN bytes memory-to-memory, ascending (LDIR-like) or descending (LDDR-like), and releases the bus. It sits beside tv80s; the top-level muxes address, data and strobes onto the memory using busak_n.

Parameters:
IO_BASE, 8'h40, I/O base; decode is cpu_a[7:3] == IO_BASE[7:3].
BURST_LEN, 16, bytes per bus tenure when DMA_FAIR_EN is defined (range 1..255).

Ports:
clk  in  1  system clock, same as the CPU clock
reset_n  in  1  asynchronous, active-low reset
cpu_a  in  8  CPU address low byte (I/O port)
cpu_do  in  8  CPU write data
cpu_iorq_n  in  1  CPU I/O request
cpu_rd_n  in  1  CPU read strobe
cpu_wr_n  in  1  CPU write strobe
io_rdata  out  8  register read data
io_hit  out  1  high while a decoded I/O read is active; top-level selects io_rdata
busrq_n  out  1  bus request to tv80s
busak_n  in  1  bus acknowledge from tv80s
dma_a  out  16  DMA memory address
dma_do  out  8  DMA write data
dma_di  in  8  memory read data
dma_mreq_n  out  1  DMA memory request
dma_rd_n  out  1  DMA read strobe
dma_wr_n  out  1  DMA write strobe
dma_done  out  1  sticky completion flag (level)

Behaviour:
- Reset values (async, reset_n=0):
  - busrq_n, dma_mreq_n, dma_rd_n, dma_wr_n = 1.
  - dma_a, dma_do, io_rdata = 0; io_hit = 0; dma_done = 0.
  - All registers = 0; state = IDLE.
- Register map (offset = cpu_a[2:0]):
  - 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN_L, 5 LEN_H.
  - 6 CTRL (write-only): bit0 START, bit1 DIR (1 = decrement), bit2 CLR_DONE.
  - 7 STATUS (read): bit0 busy, bit1 done, bits 7:2 = 0.
- Register writes:
  - Accepted once per strobe, on the first clk where cpu_iorq_n=0, cpu_wr_n=0 and decode hits. A registered previous-strobe bit blocks repeats.
  - Writes to offsets 0..5 are ignored while busy.
  - START while busy is ignored.
  - CLR_DONE is honoured at any time.
  - CTRL write with START=1 and CLR_DONE=1: done is cleared and the transfer starts.
- Register reads: combinational. io_hit = ~cpu_iorq_n & ~cpu_rd_n & decode. Offsets 0..5 return live counters; 6 reads 0.
- LEN=0 means 65536 bytes (Z80 BC semantics).
- Addresses wrap modulo 2^16 in both directions.
- FSM: IDLE, REQ, RD1, RD2, WR1, WR2, STEP, REL.
  - IDLE: on accepted START -> REQ; busy=1.
  - REQ: busrq_n=0; wait for busak_n=0 sampled on rising clk -> RD1. No DMA strobes are asserted before the grant.
  - RD1: dma_a=SRC; mreq_n=rd_n=0.
  - RD2: strobes held; dma_di latched at the end of RD2 into dma_do.
  - WR1: dma_a=DST; mreq_n=wr_n=0.
  - WR2: strobes held; deasserted entering STEP.
  - STEP: SRC/DST ±1 per DIR; LEN-1. If LEN becomes 0 -> REL, else -> RD1.
- Throughput: 5 clk per byte after grant (RD1, RD2, WR1, WR2, STEP).
- REL: busrq_n=1; wait for busak_n=1 -> IDLE. On entering IDLE: busy=0, done=1.
- Final register state: SRC/DST hold the next unprocessed address; LEN = 0.
- Deasserting busak_n mid-transfer is a protocol error. It is not recovered from; the bench must not do it.
- reset_n asserted mid-transfer: all strobes and busrq_n go high immediately (asynchronously); state returns to IDLE.

Optional Feature:
- Macro DMA_FAIR_EN.
- Defined: a tenure counter counts bytes per grant. When it reaches BURST_LEN in STEP and LEN != 0, the FSM goes to REL. After busak_n=1 it returns to REQ (not IDLE), with busy still 1 and done unchanged. The counter clears on each new grant. The CPU therefore gets at least one instruction fetch between bursts.
- Not defined: one tenure covers the whole transfer; BURST_LEN is unused.

Test Plan:
- Descending copy:
  - Setup: mem[6aef]=d6, mem[6af0]=70; SRC=6af0, DST=b5d7, LEN=0002; CTRL=03.
  - Required: mem[b5d7]=70, mem[b5d6]=d6; SRC=6aee, DST=b5d5, LEN=0000; STATUS=02.
  - Exactly 10 clk between grant and busrq_n rising.
- Ascending wrap:
  - Setup: mem[ffff]=11, mem[0000]=22; SRC=ffff, DST=0100, LEN=0002; CTRL=01.
  - Required: mem[0100]=11, mem[0101]=22; SRC=0001.
- Delayed grant: hold busak_n=1 for 20 clk after busrq_n=0 -> dma_mreq_n stays 1 throughout. The first read starts on the clk after busak_n=0.
- Busy lockout:
  - During the transfer in scenario 1, write SRC_L=55 and CTRL=01 -> both ignored; result identical to scenario 1.
  - Then write CTRL=04 -> STATUS=00.
- Reset mid-op: assert reset_n=0 during WR1 of byte 1 -> busrq_n and dma_wr_n go to 1 within the same time step; STATUS=00; destination byte not written.
- DMA_FAIR_EN, BURST_LEN=2:
  - Setup: LEN=0005.
  - Required: three grant tenures of 2, 2 and 1 bytes; done=1 only after the last one.
